mdu_32: RTL and testbench

Iterative RV32M multiply/divide unit. It sits between the 32-entry register file's read ports and its write port. It consumes operands on busA/busB, runs a 32-step shift-add or restoring-divide sequence, and drives the register file's write port (Rw/busW/RegWr) with the result. One operation is in flight at a time; the decode/control stage stalls on Busy.

---
 rtl/mdu_32_if.sv | 24 ++
 rtl/mdu_32.sv | 139 +++++++++++++
 tb/tb_mdu_32.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_32_if.sv
// rtl/mdu_32_if.sv - request/result bus between decode, register file and the multiply/divide unit
interface mdu_32_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [4:0]  Rd;
    logic        Kill;
    logic        Busy;
    logic        Done;
    logic [31:0] busW;
    logic [4:0]  Rw;
    logic        RegWr;

    modport master (
        output Start, Op, busA, busB, Rd, Kill,
        input  Busy, Done, busW, Rw, RegWr
    );

    modport slave (
        input  Start, Op, busA, busB, Rd, Kill,
        output Busy, Done, busW, Rw, RegWr
    );
endinterface

// File: rtl/mdu_32.sv
// rtl/mdu_32.sv - iterative RV32M multiply/divide unit writing the register file
module mdu_32 (
    input  logic     Clk,
    input  logic     Rst,
    mdu_32_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic        neg_a_q, neg_b_q;
    logic [31:0] mag_a_q, mag_b_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;
    logic [31:0] busw_q;
    logic [4:0]  rw_q;
    logic        busy_q, done_q, regwr_q;

    logic        sgn_a_in, sgn_b_in, neg_a_in, neg_b_in, fast_in;
    logic [31:0] mag_a_in, mag_b_in, fast_res;

    assign sgn_a_in = (bus.Op == 3'd1) || (bus.Op == 3'd2) || (bus.Op[2] && !bus.Op[0]);
    assign sgn_b_in = (bus.Op == 3'd1) || (bus.Op[2] && !bus.Op[0]);
    assign neg_a_in = sgn_a_in && bus.busA[31];
    assign neg_b_in = sgn_b_in && bus.busB[31];
    assign mag_a_in = neg_a_in ? (~bus.busA + 32'd1) : bus.busA;
    assign mag_b_in = neg_b_in ? (~bus.busB + 32'd1) : bus.busB;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign fast_in  = bus.Op[2] && ((bus.busB == 32'd0) ||
                      (!bus.Op[0] && bus.busA == 32'h8000_0000 && bus.busB == 32'hFFFF_FFFF));
    assign fast_res = (bus.busB == 32'd0) ? (bus.Op[1] ? bus.busA : 32'hFFFF_FFFF)
                                          : (bus.Op[1] ? 32'd0 : 32'h8000_0000);

    logic [32:0] mul_sum, div_rem, div_diff;
    logic [63:0] acc_d, prod_d;
    logic [31:0] mag_a_d, mag_b_d, quot_d, remv_d, result_d;

    // Multiply: right-shifting product with multiplier in mag_b.
    // Divide: dividend shifts out of mag_a while quotient bits shift in.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (mag_b_q[0] ? mag_a_q : 32'd0)};
        div_rem  = {acc_q[31:0], mag_a_q[31]};
        div_diff = div_rem - {1'b0, mag_b_q};
        acc_d    = acc_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        if (op_q[2]) begin
            acc_d   = {32'd0, (div_diff[32] ? div_rem[31:0] : div_diff[31:0])};
            mag_a_d = {mag_a_q[30:0], ~div_diff[32]};
        end else begin
            acc_d   = {mul_sum, acc_q[31:1]};
            mag_b_d = {1'b0, mag_b_q[31:1]};
        end
    end

    always_comb begin
        prod_d   = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
        quot_d   = (neg_a_q ^ neg_b_q) ? (~mag_a_q + 32'd1) : mag_a_q;
        remv_d   = neg_a_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        result_d = remv_d;
        case (op_q)
            3'd0:                   result_d = prod_d[31:0];
            3'd1, 3'd2, 3'd3:       result_d = prod_d[63:32];
            3'd4, 3'd5:             result_d = quot_d;
            default:                result_d = remv_d;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mag_a_q <= 32'd0;
            mag_b_q <= 32'd0;
            acc_q   <= 64'd0;
            cnt_q   <= 5'd0;
            busw_q  <= 32'd0;
            rw_q    <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            regwr_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            regwr_q <= 1'b0;
            if (bus.Kill && state_q != IDLE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (bus.Start && !bus.Kill) begin
                        op_q    <= bus.Op;
                        rw_q    <= bus.Rd;
                        neg_a_q <= neg_a_in;
                        neg_b_q <= neg_b_in;
                        mag_a_q <= mag_a_in;
                        mag_b_q <= mag_b_in;
                        acc_q   <= 64'd0;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b1;
                        if (fast_in) begin
                            busw_q  <= fast_res;
                            done_q  <= 1'b1;
                            regwr_q <= (bus.Rd != 5'd0);
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                    CALC: begin
                        acc_q   <= acc_d;
                        mag_a_q <= mag_a_d;
                        mag_b_q <= mag_b_d;
                        cnt_q   <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) state_q <= SIGN;
                    end
                    SIGN: begin
                        busw_q  <= result_d;
                        done_q  <= 1'b1;
                        regwr_q <= (rw_q != 5'd0);
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.busW  = busw_q;
    assign bus.Rw    = rw_q;
    assign bus.RegWr = regwr_q;
endmodule

// File: tb/tb_mdu_32.sv
// tb/tb_mdu_32.sv - self-checking bench for mdu_32 against an arithmetic reference model
module tb_mdu_32;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mdu_32_if mif();
    mdu_32 dut (.Clk(Clk), .Rst(Rst), .bus(mif));

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [31:0] ref_result(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          si, sj;
        logic        ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        si = int'(a);
        sj = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(si / sj);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(si % sj);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op >= 3'd4 && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op at the current negedge (unit idle) and wait for Done.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic [31:0] w,
                         output logic [4:0] rw, output logic wr);
        mif.Start = 1'b1; mif.Op = op; mif.busA = a; mif.busB = b; mif.Rd = rd;
        @(negedge Clk);
        mif.Start = 1'b0; mif.Op = 3'($urandom); mif.busA = $urandom; mif.busB = $urandom;
        mif.Rd = 5'($urandom);
        lat = 1;
        while (!mif.Done && lat < 80) begin
            @(negedge Clk);
            lat++;
        end
        w = mif.busW; rw = mif.Rw; wr = mif.RegWr;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        total_cnt++;
        if ({mif.Busy, mif.Done, mif.RegWr} !== 3'b000 || mif.busW !== 32'd0 || mif.Rw !== 5'd0)
            $display("FAIL reset: busy=%b done=%b regwr=%b busW=%h Rw=%0d, required all zero",
                     mif.Busy, mif.Done, mif.RegWr, mif.busW, mif.Rw);
        else pass_cnt++;
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_directed();
        vec_t v[$];
        int lat; logic [31:0] w; logic [4:0] rw; logic wr; logic [4:0] rd;
        v.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        v.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        v.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        v.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
        v.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
        v.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
        v.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        34});
        v.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         34});
        v.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        v.push_back('{3'd6, 32'd5,          32'd0,         32'd5,         1});
        v.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        v.push_back('{3'd7, 32'd5,          32'd0,         32'd5,         1});
        v.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        v.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
        v.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34});
        foreach (v[i]) begin
            rd = (i == 0) ? 5'd5 : 5'(i + 1);
            do_op(v[i].op, v[i].a, v[i].b, rd, lat, w, rw, wr);
            total_cnt++;
            if (w !== v[i].exp || lat !== v[i].lat || rw !== rd || wr !== 1'b1)
                $display("FAIL directed[%0d] op=%0d: busW=%h lat=%0d Rw=%0d RegWr=%b, required busW=%h lat=%0d Rw=%0d RegWr=1",
                         i, v[i].op, w, lat, rw, wr, v[i].exp, v[i].lat, rd);
            else pass_cnt++;
            @(negedge Clk);
            total_cnt++;
            if (mif.Busy !== 1'b0 || mif.Done !== 1'b0)
                $display("FAIL directed_retire[%0d]: busy=%b done=%b, required 0 0", i, mif.Busy, mif.Done);
            else pass_cnt++;
        end
    endtask

    task automatic test_rd0();
        int lat; logic [31:0] w; logic [4:0] rw; logic wr;
        do_op(3'd0, 32'd3, 32'd4, 5'd0, lat, w, rw, wr);
        total_cnt++;
        if (w !== 32'd12 || lat !== 34 || wr !== 1'b0 || rw !== 5'd0)
            $display("FAIL rd0: busW=%h lat=%0d RegWr=%b Rw=%0d, required 0000000c 34 0 0", w, lat, wr, rw);
        else pass_cnt++;
        @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] w; logic [4:0] rw; logic wr;
        do_op(3'd7, 32'd9, 32'd0, 5'd3, lat, w, rw, wr);
        // Start raised during the Done cycle must be dropped.
        mif.Start = 1'b1; mif.Op = 3'd5; mif.busA = 32'd50; mif.busB = 32'd0; mif.Rd = 5'd4;
        @(negedge Clk);
        mif.Start = 1'b0;
        total_cnt++;
        if (w !== 32'd9 || lat !== 1 || mif.Busy !== 1'b0 || mif.Rw !== 5'd3)
            $display("FAIL back_to_back_first: busW=%h lat=%0d busy=%b Rw=%0d, required 00000009 1 0 3",
                     w, lat, mif.Busy, mif.Rw);
        else pass_cnt++;
        do_op(3'd4, 32'd20, 32'd0, 5'd6, lat, w, rw, wr);
        total_cnt++;
        if (w !== 32'hFFFF_FFFF || lat !== 1 || rw !== 5'd6)
            $display("FAIL back_to_back_second: busW=%h lat=%0d Rw=%0d, required ffffffff 1 6", w, lat, rw);
        else pass_cnt++;
        @(negedge Clk);
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        logic [31:0] w = 32'd0;
        mif.Start = 1'b1; mif.Op = 3'd5; mif.busA = 32'd100; mif.busB = 32'd7; mif.Rd = 5'd9;
        @(negedge Clk);
        mif.Start = 1'b0;
        repeat (9) @(negedge Clk);
        mif.Start = 1'b1; mif.Op = 3'd0; mif.busA = 32'd3; mif.busB = 32'd4; mif.Rd = 5'd2;
        @(negedge Clk);
        mif.Start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (mif.Done) begin dones++; w = mif.busW; end
            @(negedge Clk);
        end
        total_cnt++;
        if (dones !== 1 || w !== 32'd14 || mif.Rw !== 5'd9)
            $display("FAIL start_ignored: dones=%0d busW=%h Rw=%0d, required 1 0000000e 9", dones, w, mif.Rw);
        else pass_cnt++;
    endtask

    task automatic test_kill();
        int lat; logic [31:0] w; logic [4:0] rw; logic wr;
        int dones = 0, wrs = 0;
        do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, lat, w, rw, wr);
        @(negedge Clk);
        mif.Start = 1'b1; mif.Op = 3'd0; mif.busA = 32'd11; mif.busB = 32'd13; mif.Rd = 5'd8;
        @(negedge Clk);
        mif.Start = 1'b0;
        repeat (19) @(negedge Clk);
        mif.Kill = 1'b1;
        @(negedge Clk);
        mif.Kill = 1'b0;
        total_cnt++;
        if (mif.Busy !== 1'b0)
            $display("FAIL kill_busy: busy=%b, required 0", mif.Busy);
        else pass_cnt++;
        for (int c = 0; c < 50; c++) begin
            if (mif.Done) dones++;
            if (mif.RegWr) wrs++;
            @(negedge Clk);
        end
        total_cnt++;
        if (dones !== 0 || wrs !== 0 || mif.busW !== ref_result(3'd3, 32'h1234_5678, 32'h9ABC_DEF0))
            $display("FAIL kill_silent: dones=%0d regwr=%0d busW=%h, required 0 0 %h", dones, wrs,
                     mif.busW, ref_result(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        mif.Start = 1'b1; mif.Op = 3'd1; mif.busA = 32'd77; mif.busB = 32'd88; mif.Rd = 5'd12;
        @(negedge Clk);
        mif.Start = 1'b0;
        repeat (14) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        total_cnt++;
        if ({mif.Busy, mif.Done, mif.RegWr} !== 3'b000 || mif.busW !== 32'd0 || mif.Rw !== 5'd0)
            $display("FAIL reset_midop: busy=%b done=%b regwr=%b busW=%h Rw=%0d, required all zero",
                     mif.Busy, mif.Done, mif.RegWr, mif.busW, mif.Rw);
        else pass_cnt++;
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_random();
        int lat; logic [31:0] w; logic [4:0] rw; logic wr;
        logic [2:0] op; logic [31:0] a, b; logic [4:0] rd;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(op, a, b, rd, lat, w, rw, wr);
            total_cnt++;
            if (w !== ref_result(op, a, b) || lat !== ref_latency(op, a, b) || rw !== rd || wr !== (rd != 5'd0))
                $display("FAIL random[%0d] op=%0d a=%h b=%h: busW=%h lat=%0d Rw=%0d RegWr=%b, required busW=%h lat=%0d Rw=%0d RegWr=%b",
                         i, op, a, b, w, lat, rw, wr, ref_result(op, a, b), ref_latency(op, a, b), rd, (rd != 5'd0));
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    initial begin
        mif.Start = 1'b0; mif.Op = 3'd0; mif.busA = 32'd0; mif.busB = 32'd0;
        mif.Rd = 5'd0; mif.Kill = 1'b0;
        test_reset();
        test_directed();
        test_rd0();
        test_back_to_back();
        test_start_ignored();
        test_kill();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
